// File: rtl/fifo_arbiter_pkg.sv
// Shared types and helpers for the FIFO round-robin arbiter.
package fifo_arb_pkg;

    // Destination class occupies the top bits of every data word.
    localparam int CLASS_W = 2;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Width of a pointer that indexes n entries (never narrower than 1 bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_arbiter_rr_grant.sv
// Combinational round-robin selector: first requester strictly after ptr.
module rr_grant #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // Cyclic search starting one past the last granted index.
    always_comb begin
        int unsigned idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin scheduler moving words from N_IN input FIFOs to N_OUT output
// FIFOs by class, with threshold configuration and error freeze.
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 2,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [ADDR_W-1:0]        umbral_full_in,
    input  logic [ADDR_W-1:0]        umbral_empty_in,
    input  logic [N_IN-1:0]          in_empty,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic [N_OUT-1:0]         out_almost_full,
    input  logic [N_IN+N_OUT-1:0]    fifo_error,
    output logic [N_IN-1:0]          pop,
    output logic [N_OUT-1:0]         push,
    output logic [DATA_W-1:0]        data_out,
    output logic [ADDR_W-1:0]        umbral_full,
    output logic [ADDR_W-1:0]        umbral_empty,
    output logic [2:0]               state_out,
    output logic                     idle,
    output logic                     error_out
);

    localparam int PW = ptr_width(N_IN);

    state_t              state, state_n;
    logic [PW-1:0]       ptr, ptr_n;
    logic                s1_valid, s1_valid_n;
    logic [PW-1:0]       s1_sel, s1_sel_n;
    logic [N_IN-1:0]     pop_n;
    logic [N_OUT-1:0]    push_n;
    logic [DATA_W-1:0]   data_out_n;
    logic [ADDR_W-1:0]   uf_n, ue_n;
    logic [N_IN-1:0]     grant;
    logic                grant_valid;
    logic [PW-1:0]       grant_idx, pop_idx;
    logic [DATA_W-1:0]   word;
    logic [CLASS_W-1:0]  dest;

    rr_grant #(.N(N_IN), .PW(PW)) u_rr (
        .ptr   (ptr),
        .req   (~in_empty),
        .grant (grant),
        .valid (grant_valid)
    );

    // One-hot to index for the new grant and for the pop currently on the wire.
    always_comb begin
        grant_idx = '0;
        pop_idx   = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant[i]) grant_idx = i[PW-1:0];
            if (pop[i])   pop_idx   = i[PW-1:0];
        end
    end

    // Read data of the input popped last cycle, and its destination class.
    always_comb begin
        word = in_data[32'(s1_sel)*DATA_W +: DATA_W];
        dest = word[DATA_W-1 -: CLASS_W];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_RESET;
        else       state <= state_n;
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n    = state;
        pop_n      = '0;
        push_n     = '0;
        data_out_n = data_out;
        ptr_n      = ptr;
        s1_valid_n = |pop;
        s1_sel_n   = pop_idx;
        uf_n       = umbral_full;
        ue_n       = umbral_empty;
        case (state)
            ST_RESET: state_n = ST_INIT;
            ST_INIT: begin
                uf_n = umbral_full_in;
                ue_n = umbral_empty_in;
                if (!init) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (init)               state_n = ST_INIT;
                else if (~in_empty != '0) state_n = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // Destination unknown before the read: every output needs slack.
                if (grant_valid && out_almost_full == '0) begin
                    pop_n = grant;
                    ptr_n = grant_idx;
                end
                if (!grant_valid && pop == '0 && !s1_valid) state_n = ST_IDLE;
            end
            ST_ERROR: ;
            default:  state_n = ST_RESET;
        endcase
        if (s1_valid) begin
            push_n[dest] = 1'b1;
            data_out_n   = word;
        end
        if (state != ST_RESET && fifo_error != '0) state_n = ST_ERROR;
        // Freeze: drop everything in flight and hold the last word.
        if (state_n == ST_ERROR) begin
            pop_n      = '0;
            push_n     = '0;
            data_out_n = data_out;
            ptr_n      = ptr;
            s1_valid_n = 1'b0;
        end
    end

    // Output, pointer and pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop          <= '0;
            push         <= '0;
            data_out     <= '0;
            umbral_full  <= '0;
            umbral_empty <= '0;
            state_out    <= '0;
            idle         <= 1'b0;
            error_out    <= 1'b0;
            ptr          <= PW'(N_IN - 1);
            s1_valid     <= 1'b0;
            s1_sel       <= '0;
        end else begin
            pop          <= pop_n;
            push         <= push_n;
            data_out     <= data_out_n;
            umbral_full  <= uf_n;
            umbral_empty <= ue_n;
            state_out    <= state_n;
            idle         <= (state_n == ST_IDLE);
            error_out    <= (state_n == ST_ERROR);
            ptr          <= ptr_n;
            s1_valid     <= s1_valid_n;
            s1_sel       <= s1_sel_n;
        end
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed and randomized bench for fifo_arbiter with a queue-based reference.
module tb_fifo_arbiter;

    localparam int DATA_W = 6;
    localparam int ADDR_W = 2;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 4;

    logic                   clk = 1'b0;
    logic                   reset, init;
    logic [ADDR_W-1:0]      umbral_full_in, umbral_empty_in;
    logic [N_IN-1:0]        in_empty;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [N_OUT-1:0]       out_almost_full;
    logic [N_IN+N_OUT-1:0]  fifo_error;
    logic [N_IN-1:0]        pop;
    logic [N_OUT-1:0]       push;
    logic [DATA_W-1:0]      data_out;
    logic [ADDR_W-1:0]      umbral_full, umbral_empty;
    logic [2:0]             state_out;
    logic                   idle, error_out;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int                m_st;
    int                m_ptr;
    logic [N_IN-1:0]   m_pop;
    logic [N_OUT-1:0]  m_push;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_uf, m_ue;
    int                flight[$];

    fifo_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_full_in  (umbral_full_in),
        .umbral_empty_in (umbral_empty_in),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .out_almost_full (out_almost_full),
        .fifo_error      (fifo_error),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .umbral_full     (umbral_full),
        .umbral_empty    (umbral_empty),
        .state_out       (state_out),
        .idle            (idle),
        .error_out       (error_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance the reference by one rising edge using the inputs the bench drove.
    task automatic model_step();
        logic [N_IN-1:0]   req, npop;
        logic [N_OUT-1:0]  npush;
        logic [DATA_W-1:0] ndata, w;
        int                nst, g, s, nptr;
        bit                found, busy, err;
        if (reset) begin
            m_st = 0; m_pop = '0; m_push = '0; m_data = '0;
            m_uf = '0; m_ue = '0; m_ptr = N_IN - 1;
            flight.delete();
            return;
        end
        req   = ~in_empty;
        found = 0;
        g     = 0;
        for (int k = 1; k <= N_IN; k++) begin
            int c;
            c = (m_ptr + k) % N_IN;
            if (!found && req[c]) begin found = 1; g = c; end
        end
        busy  = (m_pop != '0) || (flight.size() != 0);
        err   = (m_st != 0) && (fifo_error != '0);
        npop  = '0;
        npush = '0;
        ndata = m_data;
        nst   = m_st;
        nptr  = m_ptr;
        if (flight.size() != 0) begin
            s = flight.pop_front();
            w = in_data[s*DATA_W +: DATA_W];
            npush[w[DATA_W-1 -: 2]] = 1'b1;
            ndata = w;
        end
        for (int i = 0; i < N_IN; i++) if (m_pop[i]) flight.push_back(i);
        if (m_st == 1) begin m_uf = umbral_full_in; m_ue = umbral_empty_in; end
        case (m_st)
            0: nst = 1;
            1: if (!init) nst = 2;
            2: if (init) nst = 1; else if (req != '0) nst = 3;
            3: begin
                if (found && out_almost_full == '0) begin npop[g] = 1'b1; nptr = g; end
                if (!found && !busy) nst = 2;
            end
            default: ;
        endcase
        if (err) begin
            nst = 4; npop = '0; npush = '0; ndata = m_data; nptr = m_ptr;
            flight.delete();
        end
        m_st = nst; m_pop = npop; m_push = npush; m_data = ndata; m_ptr = nptr;
    endtask

    task automatic check_all();
        chk("pop",          32'(pop),          32'(m_pop));
        chk("push",         32'(push),         32'(m_push));
        chk("data_out",     32'(data_out),     32'(m_data));
        chk("umbral_full",  32'(umbral_full),  32'(m_uf));
        chk("umbral_empty", 32'(umbral_empty), 32'(m_ue));
        chk("state_out",    32'(state_out),    32'(m_st));
        chk("idle",         32'(idle),         32'(m_st == 2));
        chk("error_out",    32'(error_out),    32'(m_st == 4));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic rand_data();
        for (int i = 0; i < N_IN; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    initial begin
        int npush;
        reset = 1'b1; init = 1'b0; umbral_full_in = '0; umbral_empty_in = '0;
        in_empty = '1; in_data = '0; out_almost_full = '0; fifo_error = '0;
        m_st = 0; m_ptr = N_IN - 1; m_pop = '0; m_push = '0; m_data = '0; m_uf = '0; m_ue = '0;

        // Reset then threshold load.
        repeat (2) step();
        chk("reset_state", 32'(state_out), 32'd0);
        reset = 1'b0; init = 1'b1; umbral_full_in = 2'd2; umbral_empty_in = 2'd1;
        step();
        chk("to_init", 32'(state_out), 32'd1);
        repeat (2) step();
        init = 1'b0;
        step();
        umbral_full_in = 2'd3; umbral_empty_in = 2'd3;
        step();
        chk("to_idle", 32'(state_out), 32'd2);
        chk("uf_held", 32'(umbral_full), 32'd2);
        chk("ue_held", 32'(umbral_empty), 32'd1);

        // Single word from input 0, class 2.
        in_data[0 +: DATA_W] = 6'b10_0101;
        in_empty = 4'b1110;
        step();
        step();
        chk("single_pop", 32'(pop), 32'b0001);
        in_empty = 4'b1111;
        step();
        step();
        chk("single_push", 32'(push), 32'b0100);
        chk("single_data", 32'(data_out), 32'h25);
        step();
        chk("single_idle", 32'(idle), 32'd1);

        // Round robin across all inputs.
        in_empty = 4'b0000;
        step();
        rand_data();
        step();
        chk("rr_first", 32'(pop), 32'b0010);
        repeat (7) begin rand_data(); step(); end
        in_empty = 4'b1111;
        repeat (4) begin rand_data(); step(); end

        // Backpressure mid-stream.
        in_empty = 4'b0000;
        repeat (5) begin rand_data(); step(); end
        out_almost_full = 4'b0010;
        npush = 0;
        repeat (3) begin
            rand_data(); step();
            chk("bp_pop", 32'(pop), 32'd0);
            if (push != '0) npush++;
        end
        chk("bp_pushes", 32'(npush), 32'd2);
        out_almost_full = '0;
        step();
        chk("bp_resume", 32'(pop != '0), 32'd1);
        in_empty = 4'b1111;
        repeat (4) step();

        // Randomized traffic.
        repeat (400) begin
            rand_data();
            in_empty        = N_IN'($urandom);
            out_almost_full = ($urandom_range(0, 3) == 0) ? N_OUT'($urandom) : '0;
            init            = ($urandom_range(0, 9) == 0);
            umbral_full_in  = ADDR_W'($urandom);
            umbral_empty_in = ADDR_W'($urandom);
            step();
        end
        init = 1'b0; out_almost_full = '0;

        // Error freeze during ACTIVE.
        in_empty = 4'b0000;
        repeat (4) begin rand_data(); step(); end
        fifo_error = 8'b0010_0000;
        step();
        chk("err_state", 32'(state_out), 32'd4);
        chk("err_flag", 32'(error_out), 32'd1);
        fifo_error = '0;
        repeat (4) begin rand_data(); step(); end
        chk("err_sticky", 32'(state_out), 32'd4);
        reset = 1'b1;
        step();
        chk("err_exit", 32'(state_out), 32'd0);

        // Reset right after a pop: the word is never pushed.
        reset = 1'b0; init = 1'b1; in_empty = 4'b1111;
        repeat (2) step();
        init = 1'b0;
        step();
        in_empty = 4'b1110;
        step();
        step();
        chk("mid_pop", 32'(pop), 32'b0001);
        in_empty = 4'b1111;
        step();
        reset = 1'b1;
        step();
        chk("mid_push", 32'(push), 32'd0);
        reset = 1'b0;
        repeat (3) begin
            step();
            chk("mid_nopush", 32'(push), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
